pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Program-counter register and instruction-fetch sequencer; sits directly downstream of the PC select mux.
//  Holds the current PC, produces NEXT_PC (PC+1) back to the mux, and issues word fetches to instruction memory.
//  Presents the fetched instruction to decode/control with a valid/accept handshake.
//  Loads the mux output on accept or on redirect.
// PARAMETERS
//  ADDR_W    10       PC / instruction-memory word-address width
//  DATA_W    32       instruction width
//  RESET_PC  10'h000  PC value after reset
// PORTS
//  CLK        in   1       clock; all state updates on rising edge
//  RST        in   1       reset; synchronous, active-high
//  PC_IN      in   ADDR_W  next PC selected by the PC mux
//  IR_ACCEPT  in   1       control consumes the current instruction; load PC_IN
//  REDIRECT   in   1       abort any in-flight fetch; load PC_IN (interrupt/trap entry)
//  IMEM_ACK   in   1       instruction memory returns IMEM_DATA this cycle
//  IMEM_DATA  in   DATA_W  fetched instruction word
//  PC         out  ADDR_W  current PC
//  NEXT_PC    out  ADDR_W  PC+1, to PC mux select 0
//  IMEM_REQ   out  1       fetch request; level, held until ack
//  IMEM_ADDR  out  ADDR_W  fetch address; always equals PC
//  IR         out  DATA_W  instruction held for decode
//  IR_VALID   out  1       IR is valid for the instruction at PC
// BEHAVIOUR
//  Reset (RST high at edge): PC=RESET_PC, IR=0, IR_VALID=0, IMEM_REQ=0, state=S_IDLE; overrides all other inputs.
//  States:
//   S_IDLE -> S_REQ unconditionally next cycle. This gives one dead cycle after reset.
//   S_REQ: IMEM_REQ=1. On IMEM_ACK, capture IR<=IMEM_DATA and move to S_VALID.
//   S_VALID: IR_VALID=1, IMEM_REQ=0. On IR_ACCEPT, PC<=PC_IN and move to S_REQ.
//  Latency: first ack at earliest 1 cycle after IMEM_REQ rises. IR_VALID asserts the cycle after the ack edge.
//  Throughput: at most one instruction per 2 cycles with zero-wait memory.
//  REDIRECT (any state except reset): PC<=PC_IN, IR_VALID<=0, state<=S_REQ.
//   A same-cycle IMEM_ACK is discarded and IR is not updated.
//   A same-cycle IR_ACCEPT is ignored; REDIRECT has priority.
//  IR_ACCEPT in S_REQ or S_IDLE: ignored; PC holds.
//  PC_IN is sampled only on accept or redirect; otherwise PC holds.
//  NEXT_PC = PC + 1 modulo 2^ADDR_W; 10'h3FF wraps to 10'h000, with no carry and no flag.
//  IMEM_ADDR is combinationally PC. PC is stable while IMEM_REQ=1, except on a redirect edge.
//  IR holds its last value when IR_VALID=0; consumers must qualify IR with IR_VALID.
//  RST asserted mid-fetch: request drops next cycle. A late IMEM_ACK in S_IDLE is ignored.
//  Assertions:
//   IMEM_REQ and IR_VALID are never both 1.
//   PC changes only on RST, REDIRECT, or IR_ACCEPT in S_VALID.
// STRUCTURE
//  Shared package otter_pkg holds:
//   typedef enum logic [1:0] {S_IDLE, S_REQ, S_VALID} fetch_state_t
//   localparams PC_W=10, INSTR_W=32, RESET_VEC=10'h000
//  No sub-module is required. State register, PC register, IR register and the incrementer sit in one file.
//  The incrementer stays inline; it is not a separate adder instance.
// TESTING
//  1 Reset then zero-wait ack: PC=0, IMEM_REQ at cycle 2; ack with 32'h00000013 -> IR_VALID=1 at cycle 3, NEXT_PC=1.
//  2 Accept with PC_IN=10'h005 -> PC=5, IMEM_ADDR=5, IMEM_REQ=1 next cycle; IR_VALID=0.
//  3 Wait states: hold ack low 3 cycles -> IMEM_REQ stays 1, IMEM_ADDR stable, IR_VALID=0 throughout.
//  4 REDIRECT with PC_IN=10'h3F0 in the same cycle as IMEM_ACK -> data discarded, PC=3F0, new request issued, IR unchanged.
//  5 PC=10'h3FF -> NEXT_PC=10'h000; accept with that value -> PC=0.
//  6 RST pulse during S_REQ with a late ack -> PC=RESET_PC, IR_VALID=0, ack ignored, fetch restarts after one S_IDLE cycle.

Source files
------------

// File: rtl/otter_pkg.sv
// Shared definitions for the OTTER fetch front end: fetch sequencer
// states and the default PC / instruction widths and reset vector.
package otter_pkg;

    // Fetch sequencer states. S_IDLE only exists for the single dead
    // cycle after reset; S_REQ holds a level request to instruction
    // memory; S_VALID presents a fetched instruction to decode.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2
    } fetch_state_t;

    localparam int             PC_W      = 10;
    localparam int             INSTR_W   = 32;
    localparam logic [PC_W-1:0] RESET_VEC = 10'h000;

endpackage : otter_pkg

// File: rtl/pc_fetch_unit_checker.sv
// Protocol checker for pc_fetch_unit: request and valid are exclusive,
// and the PC only moves on reset, redirect, or an accepted instruction.
module pc_fetch_unit_checker #(
    parameter int ADDR_W = 10
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REDIRECT,
    input  logic              IR_ACCEPT,
    input  logic [ADDR_W-1:0] PC,
    input  logic              IMEM_REQ,
    input  logic              IR_VALID
);

    logic              past_valid_q;
    logic [ADDR_W-1:0] pc_prev_q;
    logic              rst_prev_q;
    logic              redirect_prev_q;
    logic              accept_ok_prev_q;

    // Arm the PC-stability check once a reset has been seen.
    always_ff @(posedge CLK) begin
        if (RST) begin
            past_valid_q <= 1'b1;
        end else begin
            past_valid_q <= past_valid_q;
        end
    end

    // Remember last cycle's PC and the conditions allowed to move it.
    always_ff @(posedge CLK) begin
        pc_prev_q        <= PC;
        rst_prev_q       <= RST;
        redirect_prev_q  <= REDIRECT;
        accept_ok_prev_q <= IR_ACCEPT & IR_VALID;
    end

    a_req_valid_excl: assert property (@(posedge CLK) !(IMEM_REQ && IR_VALID));

    a_pc_stable: assert property (@(posedge CLK) disable iff (!past_valid_q)
        (PC == pc_prev_q) || rst_prev_q || redirect_prev_q || accept_ok_prev_q);

endmodule : pc_fetch_unit_checker

// File: rtl/pc_fetch_unit.sv
// Program-counter register and instruction-fetch sequencer.
// Holds the current PC, feeds PC+1 back to the PC select mux, issues
// one word fetch per instruction and hands the fetched word to decode
// with a valid/accept handshake. A redirect (trap/interrupt entry)
// aborts any fetch in flight and restarts fetching at PC_IN.
module pc_fetch_unit
    import otter_pkg::*;
#(
    parameter int                ADDR_W   = PC_W,
    parameter int                DATA_W   = INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_VEC
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] PC_IN,
    input  logic              IR_ACCEPT,
    input  logic              REDIRECT,
    input  logic              IMEM_ACK,
    input  logic [DATA_W-1:0] IMEM_DATA,
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] NEXT_PC,
    output logic              IMEM_REQ,
    output logic [ADDR_W-1:0] IMEM_ADDR,
    output logic [DATA_W-1:0] IR,
    output logic              IR_VALID
);

    fetch_state_t      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] ir_q;
    logic              ir_valid_q;
    logic              imem_req_q;
    logic [ADDR_W-1:0] next_pc_s;

    // Inline incrementer; wraps modulo 2^ADDR_W with no carry out.
    assign next_pc_s = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};

    // Sequencer, PC and IR registers. Request and valid are registered
    // alongside the state so they are glitch-free and mutually exclusive.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= {DATA_W{1'b0}};
            ir_valid_q <= 1'b0;
            imem_req_q <= 1'b0;
        end else if (REDIRECT) begin
            // Redirect wins over a same-cycle ack (data dropped, IR kept)
            // and over a same-cycle accept.
            state_q    <= S_REQ;
            pc_q       <= PC_IN;
            ir_valid_q <= 1'b0;
            imem_req_q <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Dead cycle after reset; a stale ack here is ignored.
                    state_q    <= S_REQ;
                    ir_valid_q <= 1'b0;
                    imem_req_q <= 1'b1;
                end
                S_REQ: begin
                    // Request is held as a level until memory acks;
                    // accept is meaningless here and PC stays put.
                    if (IMEM_ACK) begin
                        state_q    <= S_VALID;
                        ir_q       <= IMEM_DATA;
                        ir_valid_q <= 1'b1;
                        imem_req_q <= 1'b0;
                    end else begin
                        state_q    <= S_REQ;
                        ir_valid_q <= 1'b0;
                        imem_req_q <= 1'b1;
                    end
                end
                S_VALID: begin
                    // Decode consumes the instruction: take the mux output
                    // and start the next fetch straight away.
                    if (IR_ACCEPT) begin
                        state_q    <= S_REQ;
                        pc_q       <= PC_IN;
                        ir_valid_q <= 1'b0;
                        imem_req_q <= 1'b1;
                    end else begin
                        state_q    <= S_VALID;
                        ir_valid_q <= 1'b1;
                        imem_req_q <= 1'b0;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a clean restart.
                    state_q    <= S_IDLE;
                    ir_valid_q <= 1'b0;
                    imem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign PC        = pc_q;
    assign NEXT_PC   = next_pc_s;
    assign IMEM_ADDR = pc_q;
    assign IMEM_REQ  = imem_req_q;
    assign IR        = ir_q;
    assign IR_VALID  = ir_valid_q;

endmodule : pc_fetch_unit

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios followed by
// randomized handshake traffic, all compared against a transaction-level
// model in which the bench also plays instruction memory.
module tb_pc_fetch_unit;

    localparam int               AW    = 10;
    localparam int               DW    = 32;
    localparam logic [AW-1:0]    RSTPC = 10'h000;

    logic          CLK;
    logic          RST;
    logic [AW-1:0] PC_IN;
    logic          IR_ACCEPT;
    logic          REDIRECT;
    logic          IMEM_ACK;
    logic [DW-1:0] IMEM_DATA;
    logic [AW-1:0] PC;
    logic [AW-1:0] NEXT_PC;
    logic          IMEM_REQ;
    logic [AW-1:0] IMEM_ADDR;
    logic [DW-1:0] IR;
    logic          IR_VALID;

    int total = 0;
    int bad   = 0;

    // Instruction memory contents (the bench answers fetches from here).
    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Reference model: where the program is, what decode currently holds,
    // whether a fetch is outstanding and whether we are in the post-reset
    // dead cycle.
    logic [AW-1:0] m_pc;
    logic [DW-1:0] m_ir;
    bit            m_have_instr;
    bit            m_fetching;
    bit            m_dead_cycle;

    pc_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(RSTPC)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .PC_IN     (PC_IN),
        .IR_ACCEPT (IR_ACCEPT),
        .REDIRECT  (REDIRECT),
        .IMEM_ACK  (IMEM_ACK),
        .IMEM_DATA (IMEM_DATA),
        .PC        (PC),
        .NEXT_PC   (NEXT_PC),
        .IMEM_REQ  (IMEM_REQ),
        .IMEM_ADDR (IMEM_ADDR),
        .IR        (IR),
        .IR_VALID  (IR_VALID)
    );

    pc_fetch_unit_checker #(.ADDR_W(AW)) chk (
        .CLK       (CLK),
        .RST       (RST),
        .REDIRECT  (REDIRECT),
        .IR_ACCEPT (IR_ACCEPT),
        .PC        (PC),
        .IMEM_REQ  (IMEM_REQ),
        .IR_VALID  (IR_VALID)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model by the rules for that
    // edge, then compare every output a little after the edge.
    task automatic step(input bit rst, input bit redir, input bit acc,
                        input bit ack, input logic [AW-1:0] pc_in);
        logic [DW-1:0] word;
        word      = mem[m_pc];
        RST       = rst;
        REDIRECT  = redir;
        IR_ACCEPT = acc;
        IMEM_ACK  = ack;
        PC_IN     = pc_in;
        IMEM_DATA = ack ? word : DW'($urandom);
        @(posedge CLK);
        #1;
        if (rst) begin
            m_pc = RSTPC; m_ir = '0;
            m_have_instr = 1'b0; m_fetching = 1'b0; m_dead_cycle = 1'b1;
        end else if (redir) begin
            m_pc = pc_in;
            m_have_instr = 1'b0; m_fetching = 1'b1; m_dead_cycle = 1'b0;
        end else if (m_dead_cycle) begin
            m_dead_cycle = 1'b0; m_fetching = 1'b1;
        end else if (m_fetching && ack) begin
            m_ir = word; m_fetching = 1'b0; m_have_instr = 1'b1;
        end else if (m_have_instr && acc) begin
            m_pc = pc_in; m_have_instr = 1'b0; m_fetching = 1'b1;
        end
        check_val("pc",        32'(PC),        32'(m_pc));
        check_val("next_pc",   32'(NEXT_PC),   32'((int'(m_pc) + 1) % (1 << AW)));
        check_val("imem_addr", 32'(IMEM_ADDR), 32'(m_pc));
        check_val("imem_req",  32'(IMEM_REQ),  32'(m_fetching));
        check_val("ir_valid",  32'(IR_VALID),  32'(m_have_instr));
        check_val("ir",        IR,             m_ir);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
        mem[0] = 32'h0000_0013;
        m_pc = RSTPC; m_ir = '0;
        m_have_instr = 1'b0; m_fetching = 1'b0; m_dead_cycle = 1'b1;

        // 1: reset, one dead cycle, request, zero-wait ack
        step(1'b1, 1'b0, 1'b0, 1'b0, 10'h000);
        step(1'b1, 1'b0, 1'b0, 1'b0, 10'h000);
        check_val("rst_req",   32'(IMEM_REQ), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 10'h000);
        check_val("req_rise",  32'(IMEM_REQ), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 10'h000);
        check_val("first_ir",  IR, 32'h0000_0013);
        check_val("first_np",  32'(NEXT_PC), 32'h001);

        // 2: accept PC_IN=5 -> fetch at 5
        step(1'b0, 1'b0, 1'b1, 1'b0, 10'h005);
        check_val("acc_addr",  32'(IMEM_ADDR), 32'h005);

        // 3: three wait states, accept during request ignored
        step(1'b0, 1'b0, 1'b0, 1'b0, 10'h111);
        step(1'b0, 1'b0, 1'b1, 1'b0, 10'h222);
        step(1'b0, 1'b0, 1'b0, 1'b0, 10'h333);

        // 4: redirect colliding with ack -> data dropped, IR unchanged
        step(1'b0, 1'b1, 1'b0, 1'b1, 10'h3F0);
        check_val("redir_ir",  IR, 32'h0000_0013);
        check_val("redir_pc",  32'(PC), 32'h3F0);

        // 5: reach 3FF, NEXT_PC wraps, accept wrapped value
        step(1'b0, 1'b0, 1'b0, 1'b1, 10'h000);
        step(1'b0, 1'b0, 1'b1, 1'b0, 10'h3FF);
        check_val("wrap_np",   32'(NEXT_PC), 32'h000);
        step(1'b0, 1'b0, 1'b0, 1'b1, 10'h000);
        step(1'b0, 1'b0, 1'b1, 1'b0, NEXT_PC);
        check_val("wrap_pc",   32'(PC), 32'h000);

        // 6: reset mid-fetch, late ack in the dead cycle ignored
        step(1'b0, 1'b0, 1'b0, 1'b0, 10'h0AA);
        step(1'b1, 1'b0, 1'b0, 1'b1, 10'h0AA);
        check_val("midrst_req", 32'(IMEM_REQ), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 10'h0BB);
        check_val("late_ack",  32'(IR_VALID), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 10'h0CC);
        check_val("restart",   IR, mem[RSTPC]);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(63) == 0), ($urandom_range(7) == 0),
                 ($urandom_range(1) == 1), ($urandom_range(1) == 1),
                 AW'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pc_fetch_unit
